// File: rtl/xosera_pkg.sv
// Shared types for the Xosera audio fetch path: bus word/address types, channel count, DMA FSM states.
package xosera_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [15:0] word_t;

    localparam int AUDIO_NCHAN = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        DELIVER
    } audio_dma_st;

endpackage

// File: rtl/audio_rr_arb.sv
// Combinational round-robin search over channel requests, starting just after the last grant.
// Latency: 0 cycles. No backpressure; o_any qualifies o_grant.
module audio_rr_arb #(
    parameter int NUM_CHAN = 4,
    localparam int IW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
    input  logic [NUM_CHAN-1:0] i_req,
    input  logic [IW-1:0]       i_ptr,
    output logic [IW-1:0]       o_grant,
    output logic                o_any
);

    logic [IW-1:0] w_idx;

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        o_grant = i_ptr;
        o_any   = 1'b0;
        w_idx   = '0;
        for (int k = NUM_CHAN; k >= 1; k--) begin
            w_idx = IW'((int'(i_ptr) + k) % NUM_CHAN);
            if (i_req[w_idx]) begin
                o_grant = w_idx;
                o_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/audio_dma_ctrl.sv
// Audio sample-fetch engine: one VRAM/TILE read per free video slot, round-robin across channels.
// Latency: slot at T -> read at T+1 -> strobe at T+2+MEM_LATENCY; slots while busy are dropped.
// Optional AUDIO_DMA_STATS_EN adds a saturating missed-slot counter (slot_miss_o, stats_clr_i).
module audio_dma_ctrl
    import xosera_pkg::*;
#(
    parameter int NUM_CHAN    = AUDIO_NCHAN,
    parameter int MEM_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic                   audio_enable_i,
    input  logic                   slot_i,
    input  logic [NUM_CHAN-1:0]    chan_fetch_i,
    input  logic [NUM_CHAN*16-1:0] chan_addr_i,
    input  logic [NUM_CHAN-1:0]    chan_tile_i,
    output logic                   vram_rd_o,
    output logic                   tile_rd_o,
    output logic [15:0]            mem_addr_o,
    input  logic [15:0]            vram_data_i,
    input  logic [15:0]            tile_data_i,
    output logic [NUM_CHAN*16-1:0] chan_word_o,
`ifdef AUDIO_DMA_STATS_EN
    output logic [7:0]             slot_miss_o,
    input  logic                   stats_clr_i,
`endif
    output logic [NUM_CHAN-1:0]    chan_strobe_o
);

    localparam int IW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam logic [1:0] WAIT_LOAD = 2'((MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0);

    audio_dma_st            r_state;
    audio_dma_st            w_state_nxt;
    logic [IW-1:0]          r_ptr;
    logic [IW-1:0]          r_gnt_ch;
    addr_t                  r_addr;
    logic                   r_tile;
    logic [1:0]             r_wait_cnt;
    logic [NUM_CHAN*16-1:0] r_words;
    logic [NUM_CHAN-1:0]    r_strobe;

    logic [IW-1:0]          w_arb_ch;
    logic                   w_arb_any;
    logic                   w_can_grant;
    logic                   w_grant;
    logic                   w_issue;
    logic                   w_capture;
    addr_t                  w_sel_addr;
    logic                   w_sel_tile;
    word_t                  w_rd_data;

    audio_rr_arb #(
        .NUM_CHAN (NUM_CHAN)
    ) u_arb (
        .i_req   (chan_fetch_i),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_ch),
        .o_any   (w_arb_any)
    );

    // DELIVER doubles as an idle cycle so back-to-back slots are not lost.
    assign w_can_grant = (r_state == IDLE) || (r_state == DELIVER);
    assign w_grant     = w_can_grant & slot_i & audio_enable_i & w_arb_any;
    assign w_issue     = (r_state == ISSUE) & audio_enable_i;
    assign w_capture   = (r_state == CAPTURE) & audio_enable_i;
    assign w_rd_data   = r_tile ? tile_data_i : vram_data_i;

    always_comb begin
        w_sel_addr = '0;
        w_sel_tile = 1'b0;
        for (int n = 0; n < NUM_CHAN; n++) begin
            if (w_arb_ch == IW'(n)) begin
                w_sel_addr = chan_addr_i[n*16 +: 16];
                w_sel_tile = chan_tile_i[n];
            end
        end
    end

    // With MEM_LATENCY of 1 there is no extra wait, so ISSUE goes straight to CAPTURE.
    always_comb begin
        w_state_nxt = r_state;
        if (!audio_enable_i) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE, DELIVER: w_state_nxt = w_grant ? ISSUE : IDLE;
                ISSUE:         w_state_nxt = (MEM_LATENCY > 1) ? WAIT : CAPTURE;
                WAIT:          w_state_nxt = (r_wait_cnt == 2'd0) ? CAPTURE : WAIT;
                CAPTURE:       w_state_nxt = DELIVER;
                default:       w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state    <= IDLE;
            r_ptr      <= IW'(NUM_CHAN - 1);
            r_gnt_ch   <= '0;
            r_addr     <= '0;
            r_tile     <= 1'b0;
            r_wait_cnt <= '0;
            r_words    <= '0;
            r_strobe   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_strobe <= '0;
            if (w_grant) begin
                r_ptr    <= w_arb_ch;
                r_gnt_ch <= w_arb_ch;
                r_addr   <= w_sel_addr;
                r_tile   <= w_sel_tile;
            end
            if (r_state == ISSUE) begin
                r_wait_cnt <= WAIT_LOAD;
            end else if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt - 2'd1;
            end
            for (int n = 0; n < NUM_CHAN; n++) begin
                if (w_capture && (r_gnt_ch == IW'(n))) begin
                    r_words[n*16 +: 16] <= w_rd_data;
                    r_strobe[n]         <= 1'b1;
                end
            end
        end
    end

`ifdef AUDIO_DMA_STATS_EN
    logic [7:0] r_slot_miss;
    logic       w_miss;

    assign w_miss = slot_i & (|chan_fetch_i) & ~w_can_grant;

    always_ff @(posedge clk) begin
        if (reset_i || stats_clr_i) begin
            r_slot_miss <= '0;
        end else if (w_miss && (r_slot_miss != 8'hFF)) begin
            r_slot_miss <= r_slot_miss + 8'd1;
        end
    end

    assign slot_miss_o = r_slot_miss;
`endif

    // Reads are gated by the enable in the same cycle, not only via the FSM.
    assign vram_rd_o     = w_issue & ~r_tile;
    assign tile_rd_o     = w_issue & r_tile;
    assign mem_addr_o    = w_issue ? r_addr : 16'h0000;
    assign chan_word_o   = r_words;
    assign chan_strobe_o = r_strobe;

endmodule

// File: tb/tb_audio_dma_ctrl.sv
// Self-checking bench for audio_dma_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
module tb_audio_dma_ctrl;

    localparam int NC  = 4;
    localparam int LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_i, audio_enable_i, slot_i;
    logic [NC-1:0]    chan_fetch_i, chan_tile_i, chan_strobe_o;
    logic [NC*16-1:0] chan_addr_i, chan_word_o;
    logic             vram_rd_o, tile_rd_o;
    logic [15:0]      mem_addr_o, vram_data_i, tile_data_i;
`ifdef AUDIO_DMA_STATS_EN
    logic [7:0]       slot_miss_o;
    logic             stats_clr_i;
`endif

    audio_dma_ctrl #(.NUM_CHAN(NC), .MEM_LATENCY(LAT)) dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .audio_enable_i (audio_enable_i),
        .slot_i         (slot_i),
        .chan_fetch_i   (chan_fetch_i),
        .chan_addr_i    (chan_addr_i),
        .chan_tile_i    (chan_tile_i),
        .vram_rd_o      (vram_rd_o),
        .tile_rd_o      (tile_rd_o),
        .mem_addr_o     (mem_addr_o),
        .vram_data_i    (vram_data_i),
        .tile_data_i    (tile_data_i),
        .chan_word_o    (chan_word_o),
`ifdef AUDIO_DMA_STATS_EN
        .slot_miss_o    (slot_miss_o),
        .stats_clr_i    (stats_clr_i),
`endif
        .chan_strobe_o  (chan_strobe_o)
    );

    // Memory model: data appears only in the cycle it is due, random garbage otherwise.
    logic [15:0] vram_mem [65536];
    logic [15:0] tile_mem [4096];
    logic        pv [LAT];
    logic        pt [LAT];
    logic [15:0] pa [LAT];
    logic        cur_v, cur_t;
    logic [15:0] cur_a;

    always begin
        @(negedge clk);
        cur_v = vram_rd_o | tile_rd_o;
        cur_t = tile_rd_o;
        cur_a = mem_addr_o;
        @(posedge clk);
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1]; pt[i] = pt[i-1]; pa[i] = pa[i-1];
        end
        pv[0] = cur_v; pt[0] = cur_t; pa[0] = cur_a;
        #1;
        vram_data_i = (pv[LAT-1] && !pt[LAT-1]) ? vram_mem[pa[LAT-1]] : 16'($urandom);
        tile_data_i = (pv[LAT-1] && pt[LAT-1])  ? tile_mem[pa[LAT-1][11:0]] : 16'($urandom);
    end

    int          cyc, checks, failures;
    bit          checking;
    int          m_rd_cyc, m_st_cyc, m_busy, m_ptr, m_st_ch, m_miss;
    logic        m_rd_t;
    logic [15:0] m_rd_a, m_st_word;
    logic [15:0] m_word [NC];
    int          strobe_log [$];
    logic [63:0] snap;
    int          rr_exp [5];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: compare against the model mid-cycle, advance the model with this cycle's inputs.
    task automatic tick();
        logic          e_rd;
        logic [NC-1:0] e_st;
        logic [63:0]   e_words;
        bit            miss;
        int            g, idx;
        @(negedge clk);
        if (cyc == m_st_cyc) m_word[m_st_ch] = m_st_word;
        e_rd    = (cyc == m_rd_cyc) && audio_enable_i;
        e_st    = (cyc == m_st_cyc) ? (NC'(1) << m_st_ch) : '0;
        e_words = '0;
        for (int n = 0; n < NC; n++) e_words[n*16 +: 16] = m_word[n];
        if (checking) begin
            chk("vram_rd", vram_rd_o, e_rd && !m_rd_t);
            chk("tile_rd", tile_rd_o, e_rd && m_rd_t);
            chk("mem_addr", mem_addr_o, e_rd ? m_rd_a : 16'h0);
            chk("strobe", chan_strobe_o, e_st);
            chk("words", chan_word_o, e_words);
`ifdef AUDIO_DMA_STATS_EN
            chk("slot_miss", slot_miss_o, m_miss);
`endif
        end
        for (int n = 0; n < NC; n++) if (chan_strobe_o[n]) strobe_log.push_back(n);

        miss = slot_i && (|chan_fetch_i) && (cyc < m_busy);
        if (reset_i) begin
            m_ptr = NC - 1;
            if (m_rd_cyc > cyc) m_rd_cyc = -1;
            if (m_st_cyc > cyc) m_st_cyc = -1;
            m_busy = cyc + 1;
            for (int n = 0; n < NC; n++) m_word[n] = 16'h0;
        end else if (!audio_enable_i) begin
            if (m_rd_cyc > cyc) m_rd_cyc = -1;
            if (m_st_cyc > cyc) m_st_cyc = -1;
            m_busy = cyc + 1;
        end else if (slot_i && (|chan_fetch_i) && cyc >= m_busy) begin
            g = -1;
            for (int k = 1; k <= NC; k++) begin
                idx = (m_ptr + k) % NC;
                if (g < 0 && chan_fetch_i[idx]) g = idx;
            end
            m_ptr     = g;
            m_rd_cyc  = cyc + 1;
            m_rd_t    = chan_tile_i[g];
            m_rd_a    = chan_addr_i[g*16 +: 16];
            m_st_cyc  = cyc + 2 + LAT;
            m_st_ch   = g;
            m_st_word = m_rd_t ? tile_mem[m_rd_a[11:0]] : vram_mem[m_rd_a];
            m_busy    = cyc + 2 + LAT;
        end
`ifdef AUDIO_DMA_STATS_EN
        if (reset_i || stats_clr_i) m_miss = 0;
        else if (miss && m_miss < 255) m_miss++;
`else
        if (miss) m_miss++;
`endif
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) vram_mem[i] = 16'($urandom);
        for (int i = 0; i < 4096; i++)  tile_mem[i] = 16'($urandom);
        vram_mem[16'h1234] = 16'hBEEF;
        tile_mem[12'hABC]  = 16'hC0DE;
        for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pt[i] = 1'b0; pa[i] = '0; end
        vram_data_i = '0; tile_data_i = '0;
        cyc = 0; checks = 0; failures = 0; checking = 0;
        m_rd_cyc = -1; m_st_cyc = -1; m_busy = 0; m_ptr = NC - 1; m_st_ch = 0; m_miss = 0;
        m_rd_t = 0; m_rd_a = '0; m_st_word = '0;
        for (int n = 0; n < NC; n++) m_word[n] = 16'h0;
        rr_exp = '{0, 1, 2, 3, 0};
        reset_i = 1; audio_enable_i = 1; slot_i = 0;
        chan_fetch_i = '0; chan_tile_i = '0; chan_addr_i = '0;
`ifdef AUDIO_DMA_STATS_EN
        stats_clr_i = 0;
`endif
        @(posedge clk); #1;

        tick(); checking = 1; tick(); tick();
        reset_i = 0;
        tick();

        // Single VRAM request on ch1
        chan_fetch_i = 4'b0010; chan_addr_i[31:16] = 16'h1234; slot_i = 1;
        tick(); slot_i = 0;
        chk("t1_vram_rd", vram_rd_o, 1'b1);
        chk("t1_addr", mem_addr_o, 16'h1234);
        tick(); tick();
        chk("t1_strobe", chan_strobe_o, 4'b0010);
        chk("t1_word", chan_word_o[31:16], 16'hBEEF);
        chan_fetch_i = '0;
        tick();

        // Round-robin fairness from reset
        reset_i = 1; tick(); reset_i = 0;
        chan_fetch_i = 4'b1111;
        for (int n = 0; n < NC; n++) chan_addr_i[n*16 +: 16] = 16'($urandom);
        strobe_log.delete();
        for (int r = 0; r < 5; r++) begin
            slot_i = 1; tick(); slot_i = 0;
            for (int w = 0; w < LAT + 2; w++) tick();
        end
        chk("rr_count", strobe_log.size(), 5);
        for (int k = 0; k < 5 && k < strobe_log.size(); k++) chk("rr_order", strobe_log[k], rr_exp[k]);
        chan_fetch_i = '0;
        tick();

        // TILE source on ch2
        chan_fetch_i = 4'b0100; chan_tile_i = 4'b0100; chan_addr_i[47:32] = 16'h0ABC; slot_i = 1;
        tick(); slot_i = 0;
        chk("t3_tile_rd", tile_rd_o, 1'b1);
        chk("t3_vram_rd", vram_rd_o, 1'b0);
        tick(); tick();
        chk("t3_word", chan_word_o[47:32], 16'hC0DE);
        chan_fetch_i = '0; chan_tile_i = '0;
        tick();

        // Slots while busy are dropped
`ifdef AUDIO_DMA_STATS_EN
        stats_clr_i = 1; tick(); stats_clr_i = 0;
`endif
        chan_fetch_i = 4'b0001; strobe_log.delete();
        slot_i = 1; tick(); tick(); tick(); slot_i = 0;
`ifdef AUDIO_DMA_STATS_EN
        chk("t4_miss2", slot_miss_o, 8'd2);
`endif
        for (int w = 0; w < LAT + 4; w++) tick();
        chk("t4_one_strobe", strobe_log.size(), 1);
`ifdef AUDIO_DMA_STATS_EN
        slot_i = 1;
        for (int w = 0; w < 500; w++) tick();
        slot_i = 0;
        chk("t4_sat", slot_miss_o, 8'hFF);
`endif
        chan_fetch_i = '0;
        for (int w = 0; w < LAT + 3; w++) tick();

        // Enable drop during the in-flight read
        chan_fetch_i = 4'b1000; chan_addr_i[63:48] = 16'($urandom); snap = chan_word_o; slot_i = 1;
        tick(); slot_i = 0;
        tick(); audio_enable_i = 0;
        tick(); audio_enable_i = 1;
        chk("t5_no_strobe", chan_strobe_o, 4'b0000);
        chk("t5_words_held", chan_word_o, snap);
        slot_i = 1; tick(); slot_i = 0;
        chk("t5_idle_regrant", vram_rd_o | tile_rd_o, 1'b1);
        chan_fetch_i = '0;
        for (int w = 0; w < LAT + 3; w++) tick();

        // Reset mid-operation
        chan_fetch_i = 4'b0110; slot_i = 1;
        tick(); slot_i = 0; reset_i = 1;
        tick(); reset_i = 0;
        chk("t6_rd", {vram_rd_o, tile_rd_o}, 2'b00);
        chk("t6_addr", mem_addr_o, 16'h0);
        chk("t6_strobe", chan_strobe_o, 4'b0000);
        chk("t6_words", chan_word_o, 64'h0);
        chan_fetch_i = 4'b1111; slot_i = 1;
        tick(); slot_i = 0;
        for (int w = 0; w < LAT + 1; w++) tick();
        chk("t6_ch0_first", chan_strobe_o, 4'b0001);
        chan_fetch_i = '0;
        tick();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            reset_i        = ($urandom_range(0, 299) == 0);
            audio_enable_i = ($urandom_range(0, 39) != 0);
            slot_i         = ($urandom_range(0, 2) == 0);
`ifdef AUDIO_DMA_STATS_EN
            stats_clr_i    = ($urandom_range(0, 199) == 0);
`endif
            for (int n = 0; n < NC; n++) begin
                if (chan_fetch_i[n] && (chan_strobe_o[n] || $urandom_range(0, 39) == 0)) begin
                    chan_fetch_i[n] = 1'b0;
                end else if (!chan_fetch_i[n] && $urandom_range(0, 3) == 0) begin
                    chan_fetch_i[n]         = 1'b1;
                    chan_addr_i[n*16 +: 16] = 16'($urandom);
                    chan_tile_i[n]          = 1'($urandom);
                end
            end
            tick();
        end
        reset_i = 0; audio_enable_i = 1; slot_i = 0; chan_fetch_i = '0;
`ifdef AUDIO_DMA_STATS_EN
        stats_clr_i = 0;
`endif
        for (int w = 0; w < LAT + 4; w++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
